mips_state_ctrl: RTL

Multi-cycle sequencer for the MIPS datapath. Owns the 3-bit state register consumed by the PC, IR, register file and memory interface. Generates the PC strobes (pcctl, PCWriteCond), memory read/write strobes, IR and register-file write enables. Handles memory waitrequest stalls, halts the CPU when execution reaches the halt address, and keeps cycle and retired-instruction counters.

---
 rtl/mips_state_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_state_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: owns the state register, drives
// the PC/IR/memory/register-file strobes, handles stalls and halt, and keeps counters.
module mips_state_ctrl #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               waitrequest,
  input  logic [31:0]        pc_value,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_branch,
  input  logic               branch_taken,
  input  logic               is_jump,
  input  logic               writes_reg,
  output logic [2:0]         state,
  output logic               pcctl,
  output logic               PCWriteCond,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               active,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'b000,
    DECODE        = 3'b001,
    EXECUTE       = 3'b010,
    MEMORY_ACCESS = 3'b011,
    WRITE_BACK    = 3'b100,
    HALT          = 3'b101
  } state_t;

  state_t               state_q, state_d;
  logic                 active_q, active_d;
  logic                 first_fetch_q, first_fetch_d;
  logic [COUNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [COUNT_W-1:0]   instr_count_q, instr_count_d;
  logic                 retire;
  logic                 halt_hit;

  // The halt address is legal as the reset vector, so the first fetch never halts.
  assign halt_hit = (pc_value == HALT_ADDR) && !first_fetch_q;

  always_comb begin
    state_d       = state_q;
    first_fetch_d = first_fetch_q;
    retire        = 1'b0;
    pcctl         = 1'b0;
    PCWriteCond   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;

    case (state_q)
      FETCH_INSTR: begin
        if (halt_hit) begin
          state_d = HALT;
        end else begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_write      = 1'b1;
            pcctl         = 1'b1;
            first_fetch_d = 1'b0;
            state_d       = DECODE;
          end
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        PCWriteCond = is_jump | (is_branch & branch_taken);
        if (is_load || is_store) begin
          state_d = MEMORY_ACCESS;
        end else if (writes_reg) begin
          state_d = WRITE_BACK;
        end else begin
          state_d = FETCH_INSTR;
          retire  = 1'b1;
        end
      end
      MEMORY_ACCESS: begin
        // A malformed load+store decode is treated as a load.
        mem_read  = is_load;
        mem_write = is_store & ~is_load;
        if (!waitrequest) begin
          if (is_load) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = FETCH_INSTR;
            retire  = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        reg_write = 1'b1;
        state_d   = FETCH_INSTR;
        retire    = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    if (reset) begin
      pcctl       = 1'b0;
      PCWriteCond = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
    end

    active_d      = (state_d != HALT);
    cycle_count_d = cycle_count_q + (active_q ? COUNT_W'(1) : COUNT_W'(0));
    instr_count_d = instr_count_q + (retire ? COUNT_W'(1) : COUNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_INSTR;
      active_q      <= 1'b0;
      first_fetch_q <= 1'b1;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      first_fetch_q <= first_fetch_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule
